car_warning_ctrl: RTL

Parametrised, clocked cabin warning controller. It monitors the ignition, NUM_DOORS door switches and NUM_SEATS seat-occupancy/seat-belt pairs, and drives a door lamp, per-seat belt lamps and a shared chime output. The seat-belt chime follows a timed pattern: grace period, then a fixed number of chime periods, then silence. The block sits between the raw (already debounced) body switches and the instrument cluster driver.

---
 rtl/car_warning_pkg.sv | 22 ++
 rtl/chime_timer.sv | 81 ++++++++
 rtl/car_warning_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/car_warning_pkg.sv
// Shared types, default parameters and helpers for the cabin warning controller.
package car_warning_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRACE = 2'd1,
        CHIME = 2'd2,
        MUTE  = 2'd3
    } belt_state_t;

    localparam int unsigned DEF_NUM_DOORS    = 4;
    localparam int unsigned DEF_NUM_SEATS    = 2;
    localparam int unsigned DEF_GRACE_CYCLES = 8;
    localparam int unsigned DEF_CHIME_PERIOD = 4;
    localparam int unsigned DEF_CHIME_COUNT  = 3;

    // Bits needed to hold 0..value-1, never less than one bit.
    function automatic int unsigned clog2_min1(input int unsigned value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/chime_timer.sv
// Grace, chime-phase and chime-period counters for the seat-belt warning sequence.
module chime_timer
    import car_warning_pkg::*;
#(
    parameter int unsigned GRACE_CYCLES = DEF_GRACE_CYCLES,
    parameter int unsigned CHIME_PERIOD = DEF_CHIME_PERIOD,
    parameter int unsigned CHIME_COUNT  = DEF_CHIME_COUNT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,        // return all counters to zero
    input  logic grace_start_i,  // entering GRACE
    input  logic grace_inc_i,    // another cycle of grace elapsed
    input  logic chime_start_i,  // entering CHIME
    input  logic chime_inc_i,    // another cycle of chiming elapsed
    output logic grace_done_o,   // this edge is the last grace cycle
    output logic chime_on_o,     // tone phase of the upcoming cycle
    output logic chime_done_o    // current cycle is the last one of the last period
);

    localparam int unsigned GW = clog2_min1(GRACE_CYCLES);
    localparam int unsigned PW = clog2_min1(CHIME_PERIOD);
    localparam int unsigned CW = clog2_min1(CHIME_COUNT);

    localparam logic [GW-1:0] GRACE_LAST  = GW'(GRACE_CYCLES - 1);
    localparam logic [PW-1:0] PHASE_LAST  = PW'(CHIME_PERIOD - 1);
    localparam logic [PW-1:0] PHASE_HALF  = PW'(CHIME_PERIOD / 2);
    localparam logic [CW-1:0] PERIOD_LAST = CW'(CHIME_COUNT - 1);

    logic [GW-1:0] grace_q, grace_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [CW-1:0] period_q, period_d;

    // Next counter values; clear outranks every start/increment request.
    always_comb begin
        grace_d  = grace_q;
        phase_d  = phase_q;
        period_d = period_q;
        if (clear_i) begin
            grace_d  = '0;
            phase_d  = '0;
            period_d = '0;
        end else begin
            if (grace_start_i) begin
                grace_d = '0;
            end else if (grace_inc_i) begin
                grace_d = grace_q + GW'(1);
            end
            if (chime_start_i) begin
                phase_d  = '0;
                period_d = '0;
            end else if (chime_inc_i) begin
                if (phase_q == PHASE_LAST) begin
                    phase_d  = '0;
                    period_d = period_q + CW'(1);
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            grace_q  <= '0;
            phase_q  <= '0;
            period_q <= '0;
        end else begin
            grace_q  <= grace_d;
            phase_q  <= phase_d;
            period_q <= period_d;
        end
    end

    assign grace_done_o = (grace_q == GRACE_LAST);
    assign chime_done_o = (phase_q == PHASE_LAST) && (period_q == PERIOD_LAST);
    // Looks at the next phase so the registered Alarm lines up with the state it enters.
    assign chime_on_o   = (phase_d < PHASE_HALF);

endmodule

// File: rtl/car_warning_ctrl.sv
// Cabin warning controller: door lamp, per-seat belt lamps and a shared chime output.
module car_warning_ctrl
    import car_warning_pkg::*;
#(
    parameter int unsigned NUM_DOORS    = DEF_NUM_DOORS,
    parameter int unsigned NUM_SEATS    = DEF_NUM_SEATS,
    parameter int unsigned GRACE_CYCLES = DEF_GRACE_CYCLES,
    parameter int unsigned CHIME_PERIOD = DEF_CHIME_PERIOD,
    parameter int unsigned CHIME_COUNT  = DEF_CHIME_COUNT
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Ignition,
    input  logic [NUM_DOORS-1:0] DoorClose,
    input  logic [NUM_SEATS-1:0] SeatOccupied,
    input  logic [NUM_SEATS-1:0] SeatBelt,
    output logic                 Alarm,
    output logic                 DoorLamp,
    output logic [NUM_SEATS-1:0] BeltLamp,
    output logic [1:0]           BeltState
);

    logic                 door_cond;
    logic                 belt_cond;
    logic [NUM_SEATS-1:0] seat_fault;

    belt_state_t          state_q, state_d;
    logic                 alarm_q, alarm_d;
    logic                 door_lamp_q;
    logic [NUM_SEATS-1:0] belt_lamp_q;

    logic tmr_clear, tmr_grace_start, tmr_grace_inc, tmr_chime_start, tmr_chime_inc;
    logic grace_done, chime_on, chime_done;

    assign door_cond  = Ignition & ~(&DoorClose);
    assign seat_fault = {NUM_SEATS{Ignition}} & SeatOccupied & ~SeatBelt;
    assign belt_cond  = |seat_fault;

    // Belt FSM next state and timer controls; a BeltCond drop outranks any counter event.
    always_comb begin
        state_d         = state_q;
        tmr_clear       = 1'b0;
        tmr_grace_start = 1'b0;
        tmr_grace_inc   = 1'b0;
        tmr_chime_start = 1'b0;
        tmr_chime_inc   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (belt_cond) begin
                    state_d         = GRACE;
                    tmr_grace_start = 1'b1;
                end
            end
            GRACE: begin
                if (!belt_cond) begin
                    state_d   = IDLE;
                    tmr_clear = 1'b1;
                end else if (grace_done) begin
                    state_d         = CHIME;
                    tmr_chime_start = 1'b1;
                end else begin
                    tmr_grace_inc = 1'b1;
                end
            end
            CHIME: begin
                if (!belt_cond) begin
                    state_d   = IDLE;
                    tmr_clear = 1'b1;
                end else if (chime_done) begin
                    state_d = MUTE;
                end else begin
                    tmr_chime_inc = 1'b1;
                end
            end
            MUTE: begin
                if (!belt_cond) begin
                    state_d   = IDLE;
                    tmr_clear = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                tmr_clear = 1'b1;
            end
        endcase
    end

    // Door warning is a steady tone that masks the chime pattern.
    always_comb begin
        alarm_d = door_cond | ((state_d == CHIME) & chime_on);
    end

    chime_timer #(
        .GRACE_CYCLES (GRACE_CYCLES),
        .CHIME_PERIOD (CHIME_PERIOD),
        .CHIME_COUNT  (CHIME_COUNT)
    ) u_chime_timer (
        .clk_i         (Clk),
        .rst_i         (Reset),
        .clear_i       (tmr_clear),
        .grace_start_i (tmr_grace_start),
        .grace_inc_i   (tmr_grace_inc),
        .chime_start_i (tmr_chime_start),
        .chime_inc_i   (tmr_chime_inc),
        .grace_done_o  (grace_done),
        .chime_on_o    (chime_on),
        .chime_done_o  (chime_done)
    );

    // FSM state and registered outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            alarm_q     <= 1'b0;
            door_lamp_q <= 1'b0;
            belt_lamp_q <= '0;
        end else begin
            state_q     <= state_d;
            alarm_q     <= alarm_d;
            door_lamp_q <= door_cond;
            belt_lamp_q <= seat_fault;  // all-zero whenever BeltCond is low
        end
    end

    assign Alarm     = alarm_q;
    assign DoorLamp  = door_lamp_q;
    assign BeltLamp  = belt_lamp_q;
    assign BeltState = state_q;

endmodule
